vga_frame_monitor: RTL and testbench

VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

---
 rtl/vga_frame_monitor.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
// Watches a pixel-rate VGA stream (syncs, blanks and 4:4:4 colour) and
// measures each frame: line length and active width of the last complete
// line, lines per frame, active lines, lit pixels and a pixel checksum.
// A report is handed to a consumer with a valid/ready handshake once per frame.
module vga_frame_monitor #(
  parameter bit HS_ACTIVE_LOW = 1'b1,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  input  logic        report_ready,
  output logic        report_valid,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic [10:0] h_active,
  output logic [10:0] v_active,
  output logic [19:0] lit_count,
  output logic [15:0] checksum,
  output logic        locked,
  output logic        dropped
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_PRIME  = 2'd1,
    ST_TRACK  = 2'd2
  } state_e;

  localparam logic [10:0] CNT11_MAX = 11'h7FF;
  localparam logic [19:0] CNT20_MAX = 20'hFFFFF;

  // Saturating increment for the 11-bit geometry counters.
  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    logic [10:0] r;
    if (v == CNT11_MAX) begin
      r = v;
    end else begin
      r = v + 11'd1;
    end
    return r;
  endfunction

  // Saturating increment for the 20-bit lit-pixel counter.
  function automatic logic [19:0] sat_inc20(input logic [19:0] v);
    logic [19:0] r;
    if (v == CNT20_MAX) begin
      r = v;
    end else begin
      r = v + 20'd1;
    end
    return r;
  endfunction

  // Frame-sync state
  state_e      state_q, state_d;

  // Input sample stage; syncs are normalised to active-high here
  logic        smp_vld_q, smp_vld_d;
  logic        hs_cur_q, hs_cur_d;
  logic        hs_prv_q, hs_prv_d;
  logic        vs_cur_q, vs_cur_d;
  logic        vs_prv_q, vs_prv_d;
  logic        act_cur_q, act_cur_d;
  logic [11:0] pix_cur_q, pix_cur_d;

  // Line accumulators and the last complete line
  logic        line_open_q, line_open_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [10:0] line_act_q, line_act_d;
  logic        line_has_act_q, line_has_act_d;
  logic [10:0] last_ht_q, last_ht_d;
  logic [10:0] last_ha_q, last_ha_d;

  // Frame accumulators
  logic [10:0] frm_vt_q, frm_vt_d;
  logic [10:0] frm_va_q, frm_va_d;
  logic [19:0] frm_lit_q, frm_lit_d;
  logic [15:0] frm_sum_q, frm_sum_d;

  // Geometry of the previously latched frame
  logic [10:0] prev_ht_q, prev_ht_d;
  logic [10:0] prev_vt_q, prev_vt_d;
  logic [10:0] prev_ha_q, prev_ha_d;
  logic [10:0] prev_va_q, prev_va_d;

  // Report registers
  logic        rep_valid_q, rep_valid_d;
  logic [10:0] rep_ht_q, rep_ht_d;
  logic [10:0] rep_vt_q, rep_vt_d;
  logic [10:0] rep_ha_q, rep_ha_d;
  logic [10:0] rep_va_q, rep_va_d;
  logic [19:0] rep_lit_q, rep_lit_d;
  logic [15:0] rep_sum_q, rep_sum_d;
  logic        rep_locked_q, rep_locked_d;
  logic        rep_dropped_q, rep_dropped_d;

  // Per-step events
  logic        step_s;
  logic        hs_edge_s;
  logic        vs_edge_s;
  logic        line_start_s;
  logic        va_inc_s;
  logic        lit_px_s;
  logic        latch_s;
  logic        geom_same_s;

  // Decode the processing step and sync leading edges from the sample stage.
  always_comb begin
    step_s       = clk_en & smp_vld_q;
    hs_edge_s    = step_s & hs_cur_q & ~hs_prv_q;
    vs_edge_s    = step_s & vs_cur_q & ~vs_prv_q;
    line_start_s = hs_edge_s | vs_edge_s;
    va_inc_s     = act_cur_q & (line_start_s | ~line_has_act_q);
    lit_px_s     = act_cur_q & (pix_cur_q != 12'd0);
    latch_s      = vs_edge_s & (state_q != ST_SEARCH);
  end

  // Register the video inputs on pixel-rate cycles and keep sync history.
  always_comb begin
    smp_vld_d = smp_vld_q;
    hs_cur_d  = hs_cur_q;
    hs_prv_d  = hs_prv_q;
    vs_cur_d  = vs_cur_q;
    vs_prv_d  = vs_prv_q;
    act_cur_d = act_cur_q;
    pix_cur_d = pix_cur_q;
    if (clk_en) begin
      smp_vld_d = 1'b1;
      hs_cur_d  = HS_ACTIVE_LOW ? ~hsync : hsync;
      vs_cur_d  = VS_ACTIVE_LOW ? ~vsync : vsync;
      hs_prv_d  = hs_cur_q;
      vs_prv_d  = vs_cur_q;
      act_cur_d = ~hblank & ~vblank;
      pix_cur_d = {vga_r, vga_g, vga_b};
    end else begin
      smp_vld_d = smp_vld_q;
    end
  end

  // Count samples per line; a line closed by an hsync edge becomes the last complete line.
  always_comb begin
    line_open_d    = line_open_q;
    line_cnt_d     = line_cnt_q;
    line_act_d     = line_act_q;
    line_has_act_d = line_has_act_q;
    last_ht_d      = last_ht_q;
    last_ha_d      = last_ha_q;
    if (step_s) begin
      if (hs_edge_s) begin
        if (line_open_q) begin
          last_ht_d = line_cnt_q;
          last_ha_d = line_act_q;
        end else begin
          last_ht_d = last_ht_q;
          last_ha_d = last_ha_q;
        end
        line_open_d = 1'b1;
        line_cnt_d  = 11'd1;
        line_act_d  = {10'd0, act_cur_q};
      end else begin
        line_cnt_d = sat_inc11(line_cnt_q);
        line_act_d = act_cur_q ? sat_inc11(line_act_q) : line_act_q;
      end
      line_has_act_d = line_start_s ? act_cur_q : (line_has_act_q | act_cur_q);
    end else begin
      line_open_d = line_open_q;
    end
  end

  // Accumulate frame totals; the vsync-edge sample is the first of the new frame.
  always_comb begin
    frm_vt_d  = frm_vt_q;
    frm_va_d  = frm_va_q;
    frm_lit_d = frm_lit_q;
    frm_sum_d = frm_sum_q;
    if (step_s) begin
      if (vs_edge_s) begin
        frm_vt_d  = {10'd0, hs_edge_s};
        frm_va_d  = {10'd0, va_inc_s};
        frm_lit_d = {19'd0, lit_px_s};
        frm_sum_d = act_cur_q ? {4'd0, pix_cur_q} : 16'd0;
      end else begin
        frm_vt_d  = hs_edge_s ? sat_inc11(frm_vt_q) : frm_vt_q;
        frm_va_d  = va_inc_s ? sat_inc11(frm_va_q) : frm_va_q;
        frm_lit_d = lit_px_s ? sat_inc20(frm_lit_q) : frm_lit_q;
        frm_sum_d = act_cur_q ? (frm_sum_q + {4'd0, pix_cur_q}) : frm_sum_q;
      end
    end else begin
      frm_sum_d = frm_sum_q;
    end
  end

  // Frame-sync FSM: two vsync edges are needed before the first full frame exists.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_edge_s) begin
          state_d = ST_PRIME;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_PRIME: begin
        if (vs_edge_s) begin
          state_d = ST_TRACK;
        end else begin
          state_d = ST_PRIME;
        end
      end
      ST_TRACK: begin
        state_d = ST_TRACK;
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // Geometry of the frame being latched against the previous frame.
  always_comb begin
    geom_same_s = (last_ht_d == prev_ht_q) && (last_ha_d == prev_ha_q) &&
                  (frm_vt_q == prev_vt_q) && (frm_va_q == prev_va_q);
  end

  // Latch frame results into the report and run the valid/ready handshake.
  always_comb begin
    rep_valid_d   = rep_valid_q;
    rep_ht_d      = rep_ht_q;
    rep_vt_d      = rep_vt_q;
    rep_ha_d      = rep_ha_q;
    rep_va_d      = rep_va_q;
    rep_lit_d     = rep_lit_q;
    rep_sum_d     = rep_sum_q;
    rep_locked_d  = rep_locked_q;
    rep_dropped_d = rep_dropped_q;
    prev_ht_d     = prev_ht_q;
    prev_vt_d     = prev_vt_q;
    prev_ha_d     = prev_ha_q;
    prev_va_d     = prev_va_q;
    if (latch_s) begin
      rep_valid_d   = 1'b1;
      rep_ht_d      = last_ht_d;
      rep_vt_d      = frm_vt_q;
      rep_ha_d      = last_ha_d;
      rep_va_d      = frm_va_q;
      rep_lit_d     = frm_lit_q;
      rep_sum_d     = frm_sum_q;
      rep_locked_d  = (state_q == ST_TRACK) & geom_same_s;
      // An unaccepted report being replaced is a drop; a coincident accept is not.
      rep_dropped_d = rep_dropped_q | (rep_valid_q & ~report_ready);
      prev_ht_d     = last_ht_d;
      prev_vt_d     = frm_vt_q;
      prev_ha_d     = last_ha_d;
      prev_va_d     = frm_va_q;
    end else if (rep_valid_q & report_ready) begin
      rep_valid_d = 1'b0;
    end else begin
      rep_valid_d = rep_valid_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_SEARCH;
      smp_vld_q      <= 1'b0;
      hs_cur_q       <= 1'b0;
      hs_prv_q       <= 1'b0;
      vs_cur_q       <= 1'b0;
      vs_prv_q       <= 1'b0;
      act_cur_q      <= 1'b0;
      pix_cur_q      <= 12'd0;
      line_open_q    <= 1'b0;
      line_cnt_q     <= 11'd0;
      line_act_q     <= 11'd0;
      line_has_act_q <= 1'b0;
      last_ht_q      <= 11'd0;
      last_ha_q      <= 11'd0;
      frm_vt_q       <= 11'd0;
      frm_va_q       <= 11'd0;
      frm_lit_q      <= 20'd0;
      frm_sum_q      <= 16'd0;
      prev_ht_q      <= 11'd0;
      prev_vt_q      <= 11'd0;
      prev_ha_q      <= 11'd0;
      prev_va_q      <= 11'd0;
      rep_valid_q    <= 1'b0;
      rep_ht_q       <= 11'd0;
      rep_vt_q       <= 11'd0;
      rep_ha_q       <= 11'd0;
      rep_va_q       <= 11'd0;
      rep_lit_q      <= 20'd0;
      rep_sum_q      <= 16'd0;
      rep_locked_q   <= 1'b0;
      rep_dropped_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      smp_vld_q      <= smp_vld_d;
      hs_cur_q       <= hs_cur_d;
      hs_prv_q       <= hs_prv_d;
      vs_cur_q       <= vs_cur_d;
      vs_prv_q       <= vs_prv_d;
      act_cur_q      <= act_cur_d;
      pix_cur_q      <= pix_cur_d;
      line_open_q    <= line_open_d;
      line_cnt_q     <= line_cnt_d;
      line_act_q     <= line_act_d;
      line_has_act_q <= line_has_act_d;
      last_ht_q      <= last_ht_d;
      last_ha_q      <= last_ha_d;
      frm_vt_q       <= frm_vt_d;
      frm_va_q       <= frm_va_d;
      frm_lit_q      <= frm_lit_d;
      frm_sum_q      <= frm_sum_d;
      prev_ht_q      <= prev_ht_d;
      prev_vt_q      <= prev_vt_d;
      prev_ha_q      <= prev_ha_d;
      prev_va_q      <= prev_va_d;
      rep_valid_q    <= rep_valid_d;
      rep_ht_q       <= rep_ht_d;
      rep_vt_q       <= rep_vt_d;
      rep_ha_q       <= rep_ha_d;
      rep_va_q       <= rep_va_d;
      rep_lit_q      <= rep_lit_d;
      rep_sum_q      <= rep_sum_d;
      rep_locked_q   <= rep_locked_d;
      rep_dropped_q  <= rep_dropped_d;
    end
  end

  assign report_valid = rep_valid_q;
  assign h_total      = rep_ht_q;
  assign v_total      = rep_vt_q;
  assign h_active     = rep_ha_q;
  assign v_active     = rep_va_q;
  assign lit_count    = rep_lit_q;
  assign checksum     = rep_sum_q;
  assign locked       = rep_locked_q;
  assign dropped      = rep_dropped_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor
// Drives a reduced VGA raster (40 samples x 24 lines; hsync and vsync pulses
// start each line/frame, active area ends each line/frame) and compares each
// frame report against totals accumulated from the driven raster.
module tb_vga_frame_monitor;

  localparam int HS_W   = 4;
  localparam int VS_W   = 2;
  localparam int H_ACT0 = 8;
  localparam int H_ACTN = 32;
  localparam int H_TOT  = 40;
  localparam int V_ACT0 = 8;
  localparam int V_TOT  = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        hsync, vsync, hblank, vblank;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        report_ready;
  logic        report_valid;
  logic [10:0] h_total, v_total, h_active, v_active;
  logic [19:0] lit_count;
  logic [15:0] checksum;
  logic        locked, dropped;

  vga_frame_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .hsync        (hsync),
    .vsync        (vsync),
    .hblank       (hblank),
    .vblank       (vblank),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .report_ready (report_ready),
    .report_valid (report_valid),
    .h_total      (h_total),
    .v_total      (v_total),
    .h_active     (h_active),
    .v_active     (v_active),
    .lit_count    (lit_count),
    .checksum     (checksum),
    .locked       (locked),
    .dropped      (dropped)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: vsync edges and reports since reset, pending/dropped
  // report status, results of the last driven frame, last reported geometry.
  int since_rst;
  int rep_cnt;
  bit m_valid;
  bit m_dropped;
  int exp_ht, exp_vt, exp_ha, exp_va, exp_lit, exp_sum;
  int prv_ht, prv_vt, prv_ha, prv_va;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"},    32'(report_valid), 32'd0);
    chk({tag, ".h_total"},  32'(h_total),      32'd0);
    chk({tag, ".v_total"},  32'(v_total),      32'd0);
    chk({tag, ".h_active"}, 32'(h_active),     32'd0);
    chk({tag, ".v_active"}, 32'(v_active),     32'd0);
    chk({tag, ".lit"},      32'(lit_count),    32'd0);
    chk({tag, ".checksum"}, 32'(checksum),     32'd0);
    chk({tag, ".locked"},   32'(locked),       32'd0);
    chk({tag, ".dropped"},  32'(dropped),      32'd0);
  endtask

  function automatic logic [11:0] colour(input int mode);
    logic [11:0] c;
    case (mode)
      0:       c = 12'h000;
      1:       c = 12'h001;
      default: c = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
    endcase
    return c;
  endfunction

  // One pixel-rate sample; returns at the negedge after it was sampled.
  task automatic send(input bit hs_a, input bit vs_a, input bit hb, input bit vb,
                      input logic [11:0] rgb);
    hsync  = ~hs_a;
    vsync  = ~vs_a;
    hblank = hb;
    vblank = vb;
    {vga_r, vga_g, vga_b} = rgb;
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  // Compare the report produced by the vsync edge that starts this frame.
  task automatic check_report(input string tag);
    bit lk;
    if (since_rst >= 2) begin
      lk = (rep_cnt >= 1) && (exp_ht == prv_ht) && (exp_vt == prv_vt) &&
           (exp_ha == prv_ha) && (exp_va == prv_va);
      if (m_valid && !report_ready) m_dropped = 1'b1;
      chk({tag, ".valid"},    32'(report_valid), 32'd1);
      chk({tag, ".h_total"},  32'(h_total),      32'(exp_ht));
      chk({tag, ".v_total"},  32'(v_total),      32'(exp_vt));
      chk({tag, ".h_active"}, 32'(h_active),     32'(exp_ha));
      chk({tag, ".v_active"}, 32'(v_active),     32'(exp_va));
      chk({tag, ".lit"},      32'(lit_count),    32'(exp_lit));
      chk({tag, ".checksum"}, 32'(checksum),     32'(exp_sum));
      chk({tag, ".locked"},   32'(locked),       32'(lk));
      chk({tag, ".dropped"},  32'(dropped),      32'(m_dropped));
      prv_ht = exp_ht; prv_vt = exp_vt; prv_ha = exp_ha; prv_va = exp_va;
      rep_cnt++;
      m_valid = !report_ready;
    end else begin
      chk({tag, ".no_report"}, 32'(report_valid), 32'd0);
    end
  endtask

  // Drive one frame and record what its report must contain.
  task automatic run_frame(input string tag, input int n_lines, input int last_len,
                           input int cmode, input bit rdy, input int rst_at,
                           input int pause_at, input bit rgap);
    int idx;
    int len;
    int f_lit;
    int f_sum;
    bit hb, vb;
    logic [11:0] rgb;
    idx = 0; f_lit = 0; f_sum = 0;
    report_ready = rdy;
    since_rst++;
    for (int y = 0; y < n_lines; y++) begin
      len = (y == n_lines - 1) ? last_len : H_TOT;
      for (int x = 0; x < len; x++) begin
        hb  = (x < H_ACT0) || (x >= H_ACT0 + H_ACTN);
        vb  = (y < V_ACT0);
        rgb = colour(cmode);
        if (!hb && !vb) begin
          f_sum += int'(rgb);
          if (rgb != 12'h000) f_lit++;
        end
        if (idx == rst_at) reset = 1'b0;
        send(x < HS_W, y < VS_W, hb, vb, rgb);
        if (idx == rst_at) begin
          reset = 1'b1;
          chk_zero({tag, ".midrst"});
          since_rst = 0; rep_cnt = 0; m_valid = 1'b0; m_dropped = 1'b0;
        end
        if (idx == 1) check_report(tag);
        if (idx == pause_at) begin
          repeat (100) @(negedge clk);
        end else if (rgap && ($urandom_range(0, 7) == 0)) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        idx++;
      end
    end
    exp_ht  = (last_len > 2047) ? 2047 : last_len;
    exp_ha  = H_ACTN;
    exp_vt  = n_lines;
    exp_va  = n_lines - V_ACT0;
    exp_lit = f_lit;
    exp_sum = f_sum % 65536;
  endtask

  initial begin
    reset = 1'b0; clk_en = 1'b0; report_ready = 1'b1;
    hsync = 1'b1; vsync = 1'b1; hblank = 1'b1; vblank = 1'b1;
    vga_r = 4'd0; vga_g = 4'd0; vga_b = 4'd0;
    since_rst = 0; rep_cnt = 0; m_valid = 1'b0; m_dropped = 1'b0;
    exp_ht = 0; exp_vt = 0; exp_ha = 0; exp_va = 0; exp_lit = 0; exp_sum = 0;
    prv_ht = 0; prv_vt = 0; prv_ha = 0; prv_va = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Lock-up on black frames, then constant 0x001 colour
    run_frame("f01_prime", V_TOT, H_TOT, 0, 1'b1, -1, -1, 1'b0);
    run_frame("f02",       V_TOT, H_TOT, 0, 1'b1, -1, -1, 1'b0);
    run_frame("f03",       V_TOT, H_TOT, 1, 1'b1, -1, -1, 1'b0);
    run_frame("f04",       V_TOT, H_TOT, 1, 1'b1, -1, -1, 1'b0);
    // Random colour, random clk_en gaps, changed line count, long mid-line pause
    run_frame("f05",       V_TOT, H_TOT, 2, 1'b1, -1, -1, 1'b1);
    run_frame("f06",       V_TOT + int'($urandom_range(1, 3)), H_TOT, 2, 1'b1, -1, -1, 1'b1);
    run_frame("f07_pause", V_TOT, H_TOT, 2, 1'b1, -1, 500, 1'b0);
    // Consumer stalls across two latches
    run_frame("f08_stall", V_TOT, H_TOT, 2, 1'b0, -1, -1, 1'b1);
    run_frame("f09_drop",  V_TOT, H_TOT, 2, 1'b0, -1, -1, 1'b1);
    report_ready = 1'b1;
    @(negedge clk);
    chk("accept.valid",   32'(report_valid), 32'd0);
    chk("accept.dropped", 32'(dropped),      32'd1);
    m_valid = 1'b0;
    // One long last line while locked, then recovery
    run_frame("f10_long",  V_TOT, H_TOT + 1, 2, 1'b1, -1, -1, 1'b0);
    run_frame("f11",       V_TOT, H_TOT, 2, 1'b1, -1, -1, 1'b0);
    run_frame("f12",       V_TOT, H_TOT, 2, 1'b1, -1, -1, 1'b0);
    // Reset mid-frame: no report until two vsync edges later
    run_frame("f13_rst",   V_TOT, H_TOT, 2, 1'b1, 300, -1, 1'b0);
    run_frame("f14_prime", V_TOT, H_TOT, 2, 1'b1, -1, -1, 1'b0);
    run_frame("f15",       V_TOT, H_TOT, 1, 1'b1, -1, -1, 1'b0);
    // Line length beyond the 11-bit range saturates
    run_frame("f16_sat",   V_TOT, 2100, 1, 1'b1, -1, -1, 1'b0);
    run_frame("f17",       V_TOT, H_TOT, 1, 1'b1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
